// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: funct3 codes, MMIO offsets,
// FSM states and the byte-lane helpers used by both decode and load return.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] OFF_LED = 32'h0000_0000;
    localparam logic [31:0] OFF_SW  = 32'h0000_0004;
    localparam logic [31:0] OFF_CYC = 32'h0000_0008;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_RESP      = 2'd2
    } state_e;

    // Byte enables for a store; funct3[1:0] carries the access size.
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Picks the addressed lane out of a full word and extends it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'b0, b};
            F3_HU:   r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage request/response bus between the pipeline (master) and the responder (slave).
interface dmem_responder_if;
    // A request transfers on a rising edge where req_valid && req_ready; the master keeps
    // fields stable while req_valid is high and unaccepted. rsp_valid is a one-cycle pulse
    // with no back-pressure: the master must take rsp_rdata/rsp_err in that cycle.
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder_ram.sv
// Single-port word RAM with per-byte write enables and one-cycle registered read.
module dmem_ram #(
    parameter int DEPTH_WORDS = 16384,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: decodes RV32I loads/stores onto block RAM and a small
// MMIO window (LED, switches, cycle counter), returning extended data or an error.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_F000
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus,
    input  logic [15:0]        sw_i,
    output logic [15:0]        led_o,
    output state_e             state_o
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);

    state_e      state_q;
    logic        rsp_valid_q, rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [15:0] led_q, sw_meta_q, sw_sync_q;
    logic [31:0] cyc_q, mmio_rdata_q;
    logic [2:0]  ld_f3_q;
    logic [1:0]  ld_off_q;
    logic        ld_mmio_q;

    logic        accept, f3_ok, misalign, in_ram, in_mmio, mmio_ok, req_err;
    logic        led_wr, cyc_wr;
    logic [31:0] mmio_off, mmio_rd, ram_wdata, ram_rdata;
    logic [3:0]  ram_we;

    assign bus.req_ready = (state_q == ST_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        f3_ok    = bus.req_we ? (bus.req_funct3 inside {F3_B, F3_H, F3_W})
                              : (bus.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        in_ram   = bus.req_addr < RAM_BYTES;
        in_mmio  = bus.req_addr >= MMIO_BASE;
        mmio_off = bus.req_addr - MMIO_BASE;
        mmio_ok  = (bus.req_funct3 == F3_W) &&
                   ((mmio_off == OFF_LED) || (mmio_off == OFF_CYC) ||
                    ((mmio_off == OFF_SW) && !bus.req_we));
        req_err  = !f3_ok || misalign || !(in_ram || (in_mmio && mmio_ok));
    end

    // Stores replicate the low byte/half across all lanes; the enables pick the live one.
    always_comb begin
        case (bus.req_funct3[1:0])
            2'b00:   ram_wdata = {4{bus.req_wdata[7:0]}};
            2'b01:   ram_wdata = {2{bus.req_wdata[15:0]}};
            default: ram_wdata = bus.req_wdata;
        endcase
        ram_we = (accept && bus.req_we && !req_err && in_ram)
                 ? byte_en(bus.req_funct3, bus.req_addr[1:0]) : 4'b0000;
        led_wr = accept && bus.req_we && !req_err && in_mmio && (mmio_off == OFF_LED);
        cyc_wr = accept && bus.req_we && !req_err && in_mmio && (mmio_off == OFF_CYC);
        case (mmio_off)
            OFF_LED: mmio_rd = {16'b0, led_q};
            OFF_SW:  mmio_rd = {16'b0, sw_sync_q};
            OFF_CYC: mmio_rd = cyc_q + 32'd1;
            default: mmio_rd = 32'b0;
        endcase
    end

    dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
        .clk     (clk),
        .en_i    (accept && in_ram),
        .we_i    (ram_we),
        .addr_i  (bus.req_addr[AW+1:2]),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'b0;
            rsp_err_q    <= 1'b0;
            led_q        <= 16'b0;
            cyc_q        <= 32'b0;
            sw_meta_q    <= 16'b0;
            sw_sync_q    <= 16'b0;
            mmio_rdata_q <= 32'b0;
            ld_f3_q      <= 3'b0;
            ld_off_q     <= 2'b0;
            ld_mmio_q    <= 1'b0;
        end else begin
            sw_meta_q   <= sw_i;
            sw_sync_q   <= sw_meta_q;
            cyc_q       <= cyc_wr ? 32'b0 : cyc_q + 32'd1;
            if (led_wr) led_q <= bus.req_wdata[15:0];
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'b0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (req_err || bus.req_we) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= req_err;
                            state_q     <= ST_RESP;
                        end else begin
                            ld_f3_q      <= bus.req_funct3;
                            ld_off_q     <= bus.req_addr[1:0];
                            ld_mmio_q    <= in_mmio;
                            mmio_rdata_q <= mmio_rd;
                            state_q      <= ST_LOAD_WAIT;
                        end
                    end
                end
                ST_LOAD_WAIT: begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= load_extend(ld_mmio_q ? mmio_rdata_q : ram_rdata,
                                               ld_f3_q, ld_off_q);
                    state_q     <= ST_RESP;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign led_o         = led_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random loads/stores scored against
// a byte-addressed memory model, an LED model and an edge-count model of the cycle counter.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int          DEPTH = 16384;
  localparam logic [31:0] MB    = 32'hFFFF_F000;
  localparam logic [31:0] RAMB  = 32'(4 * DEPTH);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw_i = 16'h0;
  logic [15:0] led_o;
  state_e      state_o;

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sw_i    (sw_i),
    .led_o   (led_o),
    .state_o (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard state
  logic [7:0]  mem_m [int unsigned];
  logic [15:0] led_m = 16'h0;
  int unsigned cyc_zero = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cyc_zero = edge_cnt;
    led_m    = 16'h0;
    rst      = 1'b0;
  endtask

  // driver: one request, then wait (bounded) for the response pulse
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                        output logic err, output int unsigned acc);
    int waitc = 0;
    @(negedge clk);
    while (!bus.req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check_eq("req_ready", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    acc            = edge_cnt;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    lat = 0; rdata = 32'h0; err = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = k; rdata = bus.rsp_rdata; err = bus.rsp_err;
        break;
      end
    end
  endtask

  // reference model: access rules applied to byte-level memory and register models
  task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int unsigned acc,
                          output logic e_err, output logic [31:0] e_rd);
    int unsigned n;
    logic        bad;
    logic [31:0] v;
    n   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad = we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!bad && (addr % n) != 0) bad = 1'b1;
    e_rd = 32'h0;
    if (!bad && addr < RAMB) begin
      if (we) begin
        for (int i = 0; i < int'(n); i++) mem_m[addr + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < int'(n); i++) v = v | (32'(mem_m[addr + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        e_rd = v;
      end
    end else if (!bad && addr >= MB && n == 4) begin
      case (addr - MB)
        32'd0: if (we) led_m = wdata[15:0]; else e_rd = {16'h0, led_m};
        32'd4: if (we) bad = 1'b1; else e_rd = {16'h0, sw_i};
        32'd8: if (we) cyc_zero = acc; else e_rd = acc - cyc_zero;
        default: bad = 1'b1;
      endcase
    end else begin
      bad = 1'b1;
    end
    e_err = bad;
    if (bad) e_rd = 32'h0;
  endtask

  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] got, output int unsigned acc);
    int          lat;
    logic        er, e_err;
    logic [31:0] e_rd;
    do_req(we, f3, addr, wdata, lat, got, er, acc);
    model_op(we, f3, addr, wdata, acc, e_err, e_rd);
    check_eq({tag, "_lat"},   32'(lat), (e_err || we) ? 32'd1 : 32'd2);
    check_eq({tag, "_err"},   {31'b0, er}, {31'b0, e_err});
    check_eq({tag, "_rdata"}, got, e_rd);
    check_eq({tag, "_led"},   {16'h0, led_o}, {16'h0, led_m});
    @(negedge clk);
    check_eq({tag, "_idle"}, bus.rsp_rdata | {31'b0, bus.rsp_valid | bus.rsp_err}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    int unsigned acc, acc0;
    int          seen;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    @(negedge clk);
    check_eq("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    check_eq("rst_rsp",   bus.rsp_rdata | {31'b0, bus.rsp_valid | bus.rsp_err}, 32'h0);
    do_reset();
    @(negedge clk);
    check_eq("rst_led", {16'h0, led_o}, 32'h0);
    check_eq("first_ready", {31'b0, bus.req_ready}, 32'd1);

    run_op("sw10",  1'b1, F3_W,  32'h10, 32'h8000_00FF, rd, acc);
    run_op("lw10",  1'b0, F3_W,  32'h10, 32'h0, rd, acc);
    check_eq("lw10_abs", rd, 32'h8000_00FF);
    run_op("lb13",  1'b0, F3_B,  32'h13, 32'h0, rd, acc);
    check_eq("lb13_abs", rd, 32'hFFFF_FF80);
    run_op("lbu13", 1'b0, F3_BU, 32'h13, 32'h0, rd, acc);
    check_eq("lbu13_abs", rd, 32'h0000_0080);

    run_op("sw20",  1'b1, F3_W, 32'h20, 32'h1234_5678, rd, acc);
    run_op("sh22",  1'b1, F3_H, 32'h22, 32'h0000_BEEF, rd, acc);
    run_op("lw20",  1'b0, F3_W, 32'h20, 32'h0, rd, acc);
    check_eq("lw20_abs", rd, 32'hBEEF_5678);
    run_op("lh22",  1'b0, F3_H, 32'h22, 32'h0, rd, acc);
    check_eq("lh22_abs", rd, 32'hFFFF_BEEF);
    run_op("lw21",  1'b0, F3_W, 32'h21, 32'h0, rd, acc);
    run_op("sh23",  1'b1, F3_H, 32'h23, 32'h0000_1111, rd, acc);
    run_op("lw20b", 1'b0, F3_W, 32'h20, 32'h0, rd, acc);
    check_eq("lw20b_abs", rd, 32'hBEEF_5678);
    run_op("bad_f3", 1'b0, 3'b011, 32'h20, 32'h0, rd, acc);

    run_op("led_wr", 1'b1, F3_W, MB, 32'h0000_A5A5, rd, acc);
    check_eq("led_abs", {16'h0, led_o}, 32'h0000_A5A5);
    sw_i = 16'h00F0;
    repeat (3) @(posedge clk);
    run_op("sw_rd",  1'b0, F3_W, MB + 32'd4, 32'h0, rd, acc);
    check_eq("sw_abs", rd, 32'h0000_00F0);
    run_op("sw_wr",  1'b1, F3_W, MB + 32'd4, 32'h1, rd, acc);

    run_op("cyc_clr", 1'b1, F3_W, MB + 32'd8, 32'h0, rd, acc0);
    for (int i = 0; i < 20 && edge_cnt < acc0 + 8; i++) @(negedge clk);
    run_op("cyc_rd", 1'b0, F3_W, MB + 32'd8, 32'h0, rd, acc);
    check_eq("cyc_gap", acc - acc0, 32'd10);
    check_eq("cyc_abs", rd, 32'd10);
    run_op("mmio_lb",  1'b0, F3_B, MB, 32'h0, rd, acc);
    run_op("unmapped", 1'b0, F3_W, 32'h0010_0000, 32'h0, rd, acc);
    run_op("ram_top_w", 1'b1, F3_W, RAMB - 32'd4, 32'hCAFE_F00D, rd, acc);
    run_op("ram_top_r", 1'b0, F3_W, RAMB - 32'd4, 32'h0, rd, acc);
    run_op("ram_end",   1'b0, F3_W, RAMB, 32'h0, rd, acc);

    // reset while a load is outstanding: no response may appear
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = F3_W; bus.req_addr = 32'h10;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check_eq("rst_drop", 32'(seen), 32'd0);
    check_eq("rst_busy", {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    cyc_zero = edge_cnt;
    led_m    = 16'h0;
    rst      = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check_eq("post_rst_led", {16'h0, led_o}, 32'h0);

    // random phase: seed the low RAM, then mixed traffic against the model
    sw_i = 16'($urandom);
    for (int a = 0; a < 256; a += 4) run_op("init", 1'b1, F3_W, 32'(a), $urandom, rd, acc);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 4) == 0) ? MB + 32'($urandom_range(0, 15))
                                      : 32'($urandom_range(0, 255));
      run_op("rand", 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, rd, acc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
